// File: rtl/vga_timing_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA timing generator with pixel-enable strobe and
//            PIPE_LAT-delayed sync/blank outputs.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter int PIPE_LAT = 0,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int XW       = 10,
   parameter int YW       = 10
) (
   input  logic          clk,
   input  logic          reset,
   output logic          pix_en,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          active,
   output logic          frame_start,
   output logic          hsync,
   output logic          vsync,
   output logic          blank_b,
   output logic          sync_b
);

   localparam int c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_hs_start = H_ACTIVE + H_FP;
   localparam int c_hs_end   = c_hs_start + H_SYNC;
   localparam int c_vs_start = V_ACTIVE + V_FP;
   localparam int c_vs_end   = c_vs_start + V_SYNC;
   localparam int c_dw       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   // Decode bit order: {hs_act, vs_act, vis}
   function automatic logic [2:0] f_decode(input logic [XW-1:0] fx, input logic [YW-1:0] fy);
      logic hs, vs, vis;
      hs  = (int'(fx) >= c_hs_start) && (int'(fx) < c_hs_end);
      vs  = (int'(fy) >= c_vs_start) && (int'(fy) < c_vs_end);
      vis = (int'(fx) < H_ACTIVE) && (int'(fy) < V_ACTIVE);
      return {hs, vs, vis};
   endfunction

   logic [c_dw-1:0] r_div;
   logic            r_pix_en;
   logic [XW-1:0]   r_x;
   logic [YW-1:0]   r_y;
   logic            r_active;
   logic            r_frame_start;

   logic            w_div_last;
   logic            w_x_wrap;
   logic            w_y_last;
   logic [XW-1:0]   w_x_nxt;
   logic [YW-1:0]   w_y_nxt;
   logic [2:0]      w_dec_cur;
   logic [2:0]      w_dec_nxt;
   logic [2:0]      w_dec_out;

   assign w_div_last = (int'(r_div) == CLK_DIV - 1);
   assign w_x_wrap   = (int'(r_x) == c_h_total - 1);
   assign w_y_last   = (int'(r_y) == c_v_total - 1);

   always_comb begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
      if (r_pix_en) begin
         if (w_x_wrap) begin
            w_x_nxt = '0;
            w_y_nxt = w_y_last ? '0 : r_y + 1'b1;
         end else begin
            w_x_nxt = r_x + 1'b1;
         end
      end
   end

   assign w_dec_cur = f_decode(r_x, r_y);
   assign w_dec_nxt = f_decode(w_x_nxt, w_y_nxt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div         <= '0;
         r_pix_en      <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_active      <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_div         <= w_div_last ? '0 : r_div + 1'b1;
         r_pix_en      <= w_div_last;
         r_x           <= w_x_nxt;
         r_y           <= w_y_nxt;
         r_active      <= w_dec_nxt[0];
         // Pulse only with the strobe that presents the (0,0) pixel
         r_frame_start <= w_div_last && (w_x_nxt == '0) && (w_y_nxt == '0);
      end
   end

   generate
      if (PIPE_LAT == 0) begin : g_no_delay
         logic [2:0] r_dec;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) r_dec <= '0;
            else       r_dec <= w_dec_nxt;
         end
         assign w_dec_out = r_dec;
      end else begin : g_delay
         // Shifted on pix_en only, so the lag is counted in pixels, not clocks
         logic [2:0] r_dly [PIPE_LAT];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < PIPE_LAT; i++) r_dly[i] <= '0;
            end else if (r_pix_en) begin
               r_dly[0] <= w_dec_cur;
               for (int i = 1; i < PIPE_LAT; i++) r_dly[i] <= r_dly[i-1];
            end
         end
         assign w_dec_out = r_dly[PIPE_LAT-1];
      end
   endgenerate

   assign pix_en      = r_pix_en;
   assign x           = r_x;
   assign y           = r_y;
   assign active      = r_active;
   assign frame_start = r_frame_start;
   assign hsync       = w_dec_out[2] ? H_POL : ~H_POL;
   assign vsync       = w_dec_out[1] ? V_POL : ~V_POL;
   assign blank_b     = w_dec_out[0];
   assign sync_b      = ~(w_dec_out[2] | w_dec_out[1]);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed self-checking bench for vga_timing_gen (four configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   logic clk;
   logic rst_a;
   logic rst_b;

   int n_vec = 0;
   int n_err = 0;

   // default 640x480, CLK_DIV=2
   logic       d_pix_en, d_active, d_frame_start, d_hsync, d_vsync, d_blank_b, d_sync_b;
   logic [9:0] d_x, d_y;
   // small frame, CLK_DIV=1, PIPE_LAT=0
   logic       s0_pix_en, s0_active, s0_frame_start, s0_hsync, s0_vsync, s0_blank_b, s0_sync_b;
   logic [2:0] s0_x, s0_y;
   // small frame, CLK_DIV=1, PIPE_LAT=2
   logic       s2_pix_en, s2_active, s2_frame_start, s2_hsync, s2_vsync, s2_blank_b, s2_sync_b;
   logic [2:0] s2_x, s2_y;
   // small frame, CLK_DIV=3, active-high syncs
   logic       p_pix_en, p_active, p_frame_start, p_hsync, p_vsync, p_blank_b, p_sync_b;
   logic [2:0] p_x, p_y;

   vga_timing_gen u_def (
      .clk(clk), .reset(rst_a), .pix_en(d_pix_en), .x(d_x), .y(d_y), .active(d_active),
      .frame_start(d_frame_start), .hsync(d_hsync), .vsync(d_vsync),
      .blank_b(d_blank_b), .sync_b(d_sync_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(1), .PIPE_LAT(0), .XW(3), .YW(3)
   ) u_s0 (
      .clk(clk), .reset(rst_b), .pix_en(s0_pix_en), .x(s0_x), .y(s0_y), .active(s0_active),
      .frame_start(s0_frame_start), .hsync(s0_hsync), .vsync(s0_vsync),
      .blank_b(s0_blank_b), .sync_b(s0_sync_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(1), .PIPE_LAT(2), .XW(3), .YW(3)
   ) u_s2 (
      .clk(clk), .reset(rst_b), .pix_en(s2_pix_en), .x(s2_x), .y(s2_y), .active(s2_active),
      .frame_start(s2_frame_start), .hsync(s2_hsync), .vsync(s2_vsync),
      .blank_b(s2_blank_b), .sync_b(s2_sync_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(3), .PIPE_LAT(0), .H_POL(1'b1), .V_POL(1'b1), .XW(3), .YW(3)
   ) u_pol (
      .clk(clk), .reset(rst_b), .pix_en(p_pix_en), .x(p_x), .y(p_y), .active(p_active),
      .frame_start(p_frame_start), .hsync(p_hsync), .vsync(p_vsync),
      .blank_b(p_blank_b), .sync_b(p_sync_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_frame(input string tag,
      input int o_pe, input int o_x, input int o_y, input int o_hs, input int o_vs,
      input int o_bl, input int o_sb, input int o_fs, input int o_act,
      input int e_pe, input int e_x, input int e_y, input int e_hs, input int e_vs,
      input int e_bl, input int e_sb, input int e_fs, input int e_act);
      chk({tag, ".pix_en"},      o_pe,  e_pe);
      chk({tag, ".x"},           o_x,   e_x);
      chk({tag, ".y"},           o_y,   e_y);
      chk({tag, ".hsync"},       o_hs,  e_hs);
      chk({tag, ".vsync"},       o_vs,  e_vs);
      chk({tag, ".blank_b"},     o_bl,  e_bl);
      chk({tag, ".sync_b"},      o_sb,  e_sb);
      chk({tag, ".frame_start"}, o_fs,  e_fs);
      chk({tag, ".active"},      o_act, e_act);
   endtask

   // Small frame: hsync x=5..6, vsync y=4, visible x<4 && y<3
   function automatic int s_hs(input int xx);  return (xx >= 5 && xx < 7) ? 1 : 0; endfunction
   function automatic int s_vs(input int yy);  return (yy == 4) ? 1 : 0; endfunction
   function automatic int s_vis(input int xx, input int yy); return (xx < 4 && yy < 3) ? 1 : 0; endfunction
   // Default frame: hsync x=656..751, vsync y=490..491, visible 640x480
   function automatic int d_hs(input int xx);  return (xx >= 656 && xx < 752) ? 1 : 0; endfunction
   function automatic int d_vs(input int yy);  return (yy >= 490 && yy < 492) ? 1 : 0; endfunction
   function automatic int d_vis(input int xx, input int yy); return (xx < 640 && yy < 480) ? 1 : 0; endfunction

   int k, sx, sy, kd, dx2, dy2, e_hs, e_vs, e_vis;
   int pp, px, py, pe;
   int dp, dx, dy;
   int hs_cnt, bl_cnt, sb_cnt;

   initial begin
      hs_cnt = 0; bl_cnt = 0; sb_cnt = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(negedge clk);

      chk_frame("rst_def", int'(d_pix_en), int'(d_x), int'(d_y), int'(d_hsync), int'(d_vsync),
                int'(d_blank_b), int'(d_sync_b), int'(d_frame_start), int'(d_active),
                0, 0, 0, 1, 1, 0, 1, 0, 0);
      chk_frame("rst_s2", int'(s2_pix_en), int'(s2_x), int'(s2_y), int'(s2_hsync), int'(s2_vsync),
                int'(s2_blank_b), int'(s2_sync_b), int'(s2_frame_start), int'(s2_active),
                0, 0, 0, 1, 1, 0, 1, 0, 0);
      chk_frame("rst_pol", int'(p_pix_en), int'(p_x), int'(p_y), int'(p_hsync), int'(p_vsync),
                int'(p_blank_b), int'(p_sync_b), int'(p_frame_start), int'(p_active),
                0, 0, 0, 0, 0, 0, 1, 0, 0);

      rst_a = 1'b0;
      rst_b = 1'b0;

      // Sample j is taken at the falling edge after the j-th rising edge since release
      for (int j = 1; j <= 32601; j++) begin
         @(negedge clk);
         if (j <= 300) begin
            k  = j - 1;
            sx = k % 8;
            sy = (k / 8) % 6;
            chk_frame("s0", int'(s0_pix_en), int'(s0_x), int'(s0_y), int'(s0_hsync), int'(s0_vsync),
                      int'(s0_blank_b), int'(s0_sync_b), int'(s0_frame_start), int'(s0_active),
                      1, sx, sy, 1 - s_hs(sx), 1 - s_vs(sy), s_vis(sx, sy),
                      1 - (s_hs(sx) | s_vs(sy)), (k % 48 == 0) ? 1 : 0, s_vis(sx, sy));

            if (k >= 2) begin
               kd    = k - 2;
               dx2   = kd % 8;
               dy2   = (kd / 8) % 6;
               e_hs  = s_hs(dx2);
               e_vs  = s_vs(dy2);
               e_vis = s_vis(dx2, dy2);
            end else begin
               e_hs = 0; e_vs = 0; e_vis = 0;
            end
            chk_frame("s2", int'(s2_pix_en), int'(s2_x), int'(s2_y), int'(s2_hsync), int'(s2_vsync),
                      int'(s2_blank_b), int'(s2_sync_b), int'(s2_frame_start), int'(s2_active),
                      1, sx, sy, 1 - e_hs, 1 - e_vs, e_vis, 1 - (e_hs | e_vs),
                      (k % 48 == 0) ? 1 : 0, s_vis(sx, sy));

            pp = (j - 1) / 3;
            px = pp % 8;
            py = (pp / 8) % 6;
            pe = (j % 3 == 0) ? 1 : 0;
            chk_frame("pol", int'(p_pix_en), int'(p_x), int'(p_y), int'(p_hsync), int'(p_vsync),
                      int'(p_blank_b), int'(p_sync_b), int'(p_frame_start), int'(p_active),
                      pe, px, py, s_hs(px), s_vs(py), s_vis(px, py),
                      1 - (s_hs(px) | s_vs(py)), (pe == 1 && pp % 48 == 0) ? 1 : 0, s_vis(px, py));
         end

         if (j <= 1610) begin
            dp = (j - 1) / 2;
            dx = dp % 800;
            dy = dp / 800;
            pe = (j % 2 == 0) ? 1 : 0;
            chk_frame("def", int'(d_pix_en), int'(d_x), int'(d_y), int'(d_hsync), int'(d_vsync),
                      int'(d_blank_b), int'(d_sync_b), int'(d_frame_start), int'(d_active),
                      pe, dx, dy, 1 - d_hs(dx), 1 - d_vs(dy), d_vis(dx, dy),
                      1 - (d_hs(dx) | d_vs(dy)), (pe == 1 && dp == 0) ? 1 : 0, d_vis(dx, dy));
            if (pe == 1 && dy == 0) begin
               if (d_hsync == 1'b0)  hs_cnt++;
               if (d_blank_b == 1'b1) bl_cnt++;
               if (d_sync_b == 1'b0)  sb_cnt++;
            end
         end
      end

      chk("def.hsync_width_line0", hs_cnt, 96);
      chk("def.visible_line0", bl_cnt, 640);
      chk("def.sync_b_low_line0", sb_cnt, 96);
      chk("def.mid_x", int'(d_x), 300);
      chk("def.mid_y", int'(d_y), 20);

      // Asynchronous reset mid-line, well away from any clock edge
      #2 rst_a = 1'b1;
      #1;
      chk_frame("midrst", int'(d_pix_en), int'(d_x), int'(d_y), int'(d_hsync), int'(d_vsync),
                int'(d_blank_b), int'(d_sync_b), int'(d_frame_start), int'(d_active),
                0, 0, 0, 1, 1, 0, 1, 0, 0);
      @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      chk("rel1.pix_en", int'(d_pix_en), 0);
      chk("rel1.frame_start", int'(d_frame_start), 0);
      @(negedge clk);
      chk("rel2.pix_en", int'(d_pix_en), 1);
      chk("rel2.frame_start", int'(d_frame_start), 1);
      chk("rel2.x", int'(d_x), 0);
      chk("rel2.y", int'(d_y), 0);
      @(negedge clk);
      chk("rel3.pix_en", int'(d_pix_en), 0);
      chk("rel3.frame_start", int'(d_frame_start), 0);
      chk("rel3.x", int'(d_x), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
